remap_mode_ctrl: RTL



---
 rtl/remap_ctrl_pkg.sv | 36 +++
 rtl/vsync_edge_det.sv | 23 ++
 rtl/remap_mode_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/remap_ctrl_pkg.sv
// Shared types and constants for the RGB remap mode controller.
package remap_ctrl_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StSettle = 2'd2
  } state_e;

  // Mode bus field positions: [3] bypass, [2] invert, [1:0] LUT bank.
  localparam int unsigned MODE_BYPASS   = 3;
  localparam int unsigned MODE_INVERT   = 2;
  localparam int unsigned MODE_BANK_MSB = 1;
  localparam int unsigned MODE_BANK_LSB = 0;

  // Bypass with bank 0.
  localparam logic [3:0] RESET_MODE_DEFAULT = 4'b1000;

  // Same mode with bypass forced on, shown while the ROM pipeline refills.
  function automatic logic [3:0] force_bypass(input logic [3:0] mode);
    logic [3:0] m;
    m = mode;
    m[MODE_BYPASS] = 1'b1;
    return m;
  endfunction

  // Same mode with the LUT bank advanced by one, wrapping 3 -> 0.
  function automatic logic [3:0] advance_bank(input logic [3:0] mode);
    logic [3:0] m;
    m = mode;
    m[MODE_BANK_MSB:MODE_BANK_LSB] = mode[MODE_BANK_MSB:MODE_BANK_LSB] + 2'd1;
    return m;
  endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Rising-edge detector for frame sync. The history register resets high so
// that a sync level already present at reset release is not seen as an edge.
module vsync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic frame_start_o
);

  logic vsync_q;

  // Remember last cycle's sync level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  assign frame_start_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/remap_mode_ctrl.sv
// Mode sequencer for the per-channel RGB remap LUT stage. Host requests are
// applied only at frame start, followed by a forced-bypass settle window.
// Optional automatic bank cycling is built when REMAP_MODE_CTRL_AUTO_CYCLE_EN
// is defined; otherwise auto_en and auto_period are ignored.
module remap_mode_ctrl
  import remap_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  RESET_MODE    = RESET_MODE_DEFAULT,
  parameter int unsigned PERIOD_W      = 8
) (
  input  logic                pixclk,
  input  logic                rst_n,
  input  logic                vsync_in,
  input  logic [3:0]          host_mode,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] auto_period,
  output logic [3:0]          mode_out,
  output logic                mode_update,
  output logic                busy
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          mode_q, mode_d;
  logic [3:0]          pending_q, pending_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic                update_q, update_d;
  logic                frame_start;
  logic                accept;
  logic                auto_hit;

  vsync_edge_det u_vsync_edge_det (
    .clk_i         (pixclk),
    .rst_ni        (rst_n),
    .vsync_i       (vsync_in),
    .frame_start_o (frame_start)
  );

  // Held low during reset so nothing is accepted before the controller runs.
  assign host_ready = (state_q == StIdle) & rst_n;
  assign accept     = host_valid & host_ready;

`ifdef REMAP_MODE_CTRL_AUTO_CYCLE_EN
  logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                auto_on;
  logic [PERIOD_W-1:0] period_last;

  assign auto_on     = auto_en & (auto_period != '0);
  assign period_last = auto_period - 1'b1;
  // Host accept has priority, so the trigger is suppressed in its cycle.
  assign auto_hit    = (state_q == StIdle) & auto_on & frame_start & ~accept &
                       (frame_cnt_q == period_last);

  // Frame counter: counts frame starts in IDLE, clears on accept, on a trigger
  // and when it already sits past a shortened period.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == StIdle) begin
      if (accept || !auto_on) begin
        frame_cnt_d = '0;
      end else if (frame_start) begin
        if (frame_cnt_q >= period_last) begin
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // Frame counter register.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  logic unused_auto;

  assign auto_hit    = 1'b0;
  assign unused_auto = ^{auto_en, auto_period};
`endif

  // Next-state and mode sequencing.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    settle_d  = settle_q;
    update_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          // A frame start in this cycle is deliberately not used.
          pending_d = host_mode;
          state_d   = StArmed;
        end else if (auto_hit) begin
          pending_d = advance_bank(mode_q);
          mode_d    = force_bypass(advance_bank(mode_q));
          settle_d  = SettleLoad;
          state_d   = StSettle;
        end
      end
      StArmed: begin
        if (frame_start) begin
          mode_d   = force_bypass(pending_q);
          settle_d = SettleLoad;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        // Frame starts here are ignored; the window is never restarted.
        if (settle_q == '0) begin
          mode_d   = pending_q;
          update_d = 1'b1;
          state_d  = StIdle;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and mode registers.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= RESET_MODE;
      pending_q <= '0;
      settle_q  <= '0;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      settle_q  <= settle_d;
      update_q  <= update_d;
    end
  end

  assign mode_out    = mode_q;
  assign mode_update = update_q;
  assign busy        = (state_q != StIdle);

endmodule
